// File: rtl/fp_min_reduce_ctrl_if.sv
// fp_min_reduce_ctrl_if: operand stream in, reduction result out, valid/ready on both sides.
interface fp_min_reduce_ctrl_if #(
    parameter int W     = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [4:0]       out_status;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_status, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_status, out_count
    );
endinterface

// File: rtl/fp_min_reduce_ctrl.sv
// fp_min_reduce_ctrl: folds a last-terminated float stream into its minimum, with sNaN sticky flag and element count.
module fp_min_reduce_ctrl #(
    parameter int SIGN_W = 1,
    parameter int EXPO_W = 8,
    parameter int MANT_W = 23,
    parameter int CNT_W  = 16
) (
    input logic                 clk,
    input logic                 rst,
    fp_min_reduce_ctrl_if.slave bus
);
    localparam int W = SIGN_W + EXPO_W + MANT_W;
    localparam int M = EXPO_W + MANT_W;

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic             fire, first, done;

    function automatic logic is_nan(input logic [W-1:0] x);
        return (&x[MANT_W +: EXPO_W]) && (|x[MANT_W-1:0]);
    endfunction

    function automatic logic is_snan(input logic [W-1:0] x);
        return is_nan(x) && !x[MANT_W-1];
    endfunction

    function automatic logic is_zero(input logic [W-1:0] x);
        return ~|x[M-1:0];
    endfunction

    // Infinities need no special case: {expo,mant} magnitude ordering already ranks them.
    function automatic logic [W-1:0] fmin(input logic [W-1:0] a, input logic [W-1:0] b);
        if (is_nan(b)) return a;
        if (is_nan(a)) return b;
        if (is_zero(a) && is_zero(b)) return a;
        if (a[W-1] != b[W-1]) return a[W-1] ? a : b;
        return (a[W-1] ? b[M-1:0] > a[M-1:0] : b[M-1:0] < a[M-1:0]) ? b : a;
    endfunction

    assign done  = state_q == DONE;
    assign fire  = bus.in_valid && !done;
    assign first = state_q == IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (fire) begin
            state_d  = bus.in_last ? DONE : ACC;
            acc_d    = first ? bus.in_data : fmin(acc_q, bus.in_data);
            cnt_d    = first ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + CNT_W'(1));
            sticky_d = (!first && sticky_q) || is_snan(bus.in_data);
        end else if (done && bus.out_ready) begin
            state_d  = IDLE;
            cnt_d    = '0;
            sticky_d = 1'b0;
        end
    end

    always_comb begin
        bus.in_ready   = !rst && !done;
        bus.out_valid  = done;
        bus.out_data   = done ? acc_q : '0;
        bus.out_status = done ? {sticky_q, 4'b0} : 5'b0;
        bus.out_count  = done ? cnt_q : '0;
    end
endmodule

// File: tb/tb_fp_min_reduce_ctrl.sv
// tb_fp_min_reduce_ctrl: table of vectors plus handshake/reset sequences; a CNT_W=2 twin runs in lockstep for saturation.
module tb_fp_min_reduce_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_data = '0;

    always #5 clk = ~clk;

    fp_min_reduce_ctrl_if #(.W(32), .CNT_W(16)) ifa ();
    fp_min_reduce_ctrl_if #(.W(32), .CNT_W(2))  ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_data   = in_data;
    assign ifa.in_last   = in_last;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_data   = in_data;
    assign ifb.in_last   = in_last;
    assign ifb.out_ready = out_ready;

    fp_min_reduce_ctrl #(.CNT_W(16)) dut     (.clk(clk), .rst(rst), .bus(ifa.slave));
    fp_min_reduce_ctrl #(.CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(ifb.slave));

    typedef struct {
        int              n;
        logic [0:4][31:0] e;
        logic [31:0]     d;
        logic [4:0]      s;
        int              c;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  s;
        int          c;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[11];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic [4:0] s, input int c);
        exp_t x;
        x.d = d;
        x.s = s;
        x.c = c;
        sb.push_back(x);
    endtask

    task automatic drive(input logic [31:0] d, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        chk("in_ready", ifa.in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send(input vec_t v);
        for (int i = 0; i < v.n; i++) drive(v.e[i], i == v.n - 1);
        push(v.d, v.s, v.c);
    endtask

    task automatic get_result(input string nm);
        exp_t x;
        int   w = 0;
        out_ready = 1'b1;
        @(negedge clk);
        while (!ifa.out_valid && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk({nm, " latency"}, w, 0);
        chk({nm, " queued"}, sb.size() != 0, 1);
        if (sb.size() != 0) begin
            x = sb.pop_front();
            chk({nm, " data"}, ifa.out_data, x.d);
            chk({nm, " status"}, ifa.out_status, x.s);
            chk({nm, " count"}, ifa.out_count, x.c);
            chk({nm, " sat_count"}, ifb.out_count, x.c > 3 ? 3 : x.c);
            chk({nm, " in_ready_busy"}, ifa.in_ready, 0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{3, {32'h40400000, 32'hBFC00000, 32'h40000000, 32'h0, 32'h0}, 32'hBFC00000, 5'h00, 3};
        tbl[1]  = '{2, {32'h7FC00000, 32'h40A00000, 32'h0, 32'h0, 32'h0}, 32'h40A00000, 5'h00, 2};
        tbl[2]  = '{2, {32'h7FA00000, 32'h3F800000, 32'h0, 32'h0, 32'h0}, 32'h3F800000, 5'h10, 2};
        tbl[3]  = '{2, {32'h7FA00000, 32'h7FC00001, 32'h0, 32'h0, 32'h0}, 32'h7FA00000, 5'h10, 2};
        tbl[4]  = '{2, {32'h00000000, 32'h80000000, 32'h0, 32'h0, 32'h0}, 32'h00000000, 5'h00, 2};
        tbl[5]  = '{2, {32'h80000000, 32'h00000000, 32'h0, 32'h0, 32'h0}, 32'h80000000, 5'h00, 2};
        tbl[6]  = '{3, {32'h7F800000, 32'hFF800000, 32'hC2C80000, 32'h0, 32'h0}, 32'hFF800000, 5'h00, 3};
        tbl[7]  = '{5, {32'h3F800000, 32'h40000000, 32'hC0000000, 32'hBF800000, 32'hC0400000}, 32'hC0400000, 5'h00, 5};
        tbl[8]  = '{2, {32'h00000002, 32'h00000001, 32'h0, 32'h0, 32'h0}, 32'h00000001, 5'h00, 2};
        tbl[9]  = '{2, {32'hBF800000, 32'hBF800001, 32'h0, 32'h0, 32'h0}, 32'hBF800001, 5'h00, 2};
        tbl[10] = '{3, {32'h3F800000, 32'h7F800001, 32'h40000000, 32'h0, 32'h0}, 32'h3F800000, 5'h10, 3};

        @(negedge clk);
        chk("rst in_ready", ifa.in_ready, 0);
        chk("rst out_valid", ifa.out_valid, 0);
        chk("rst out_data", ifa.out_data, 0);
        chk("rst out_status", ifa.out_status, 0);
        chk("rst out_count", ifa.out_count, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst in_ready", ifa.in_ready, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) begin
            send(tbl[i]);
            get_result($sformatf("vec%0d", i));
        end

        // Result held under backpressure while a new operand waits on the input.
        out_ready = 1'b0;
        drive(32'hC1200000, 1'b0);
        drive(32'h3F000000, 1'b1);
        push(32'hC1200000, 5'h00, 2);
        in_valid = 1'b1;
        in_data  = 32'h12345678;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp out_valid", ifa.out_valid, 1);
            chk("bp out_data", ifa.out_data, 32'hC1200000);
            chk("bp out_count", ifa.out_count, 2);
            chk("bp in_ready", ifa.in_ready, 0);
            @(posedge clk);
            #1;
        end
        push(32'h12345678, 5'h00, 1);
        get_result("bp_release");
        @(negedge clk);
        chk("bp_next in_ready", ifa.in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        get_result("bp_single");

        // Reset in the middle of a vector drops the partial result.
        drive(32'hC0000000, 1'b0);
        drive(32'hC1000000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst in_ready", ifa.in_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst out_valid", ifa.out_valid, 0);
        chk("mid_rst out_data", ifa.out_data, 0);
        chk("mid_rst out_status", ifa.out_status, 0);
        chk("mid_rst out_count", ifa.out_count, 0);
        chk("mid_rst in_ready_after", ifa.in_ready, 1);
        @(posedge clk);
        #1;
        drive(32'h3F800000, 1'b1);
        push(32'h3F800000, 5'h00, 1);
        get_result("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/fp_min_reduce_ctrl.md
# fp_min_reduce_ctrl

Sequential min-reduction controller for IEEE-style binary floating point. It accepts a stream of operands over a valid/ready handshake, with a last-marker closing each vector. It folds each vector into a running minimum through one internal min compare per cycle and presents the result with sticky exception status and an element count. It sits between a vector operand source and the result writeback, sequencing the min datapath across multi-element reductions.

## Interface
- SIGN_W, 1, sign field width
- EXPO_W, 8, exponent field width
- MANT_W, 23, mantissa field width
- CNT_W, 16, element counter width
- Reset: one clock; reset is synchronous and active-high.

- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand valid
- in_ready  out  1  controller accepts operand
- in_data  in  SIGN_W+EXPO_W+MANT_W  operand, {sign, expo, mant}
- in_last  in  1  operand is final element of vector
- out_valid  out  1  reduction result valid
- out_ready  in  1  consumer accepts result
- out_data  out  SIGN_W+EXPO_W+MANT_W  minimum of vector
- out_status  out  5  exception flags; [4] invalid, [3:0] always 0
- out_count  out  CNT_W  elements in vector, saturating

## Operation
- Internal classification per operand:
  - nan = expo all-ones and mant != 0
  - snan = nan and mant MSB == 0
  - inf = expo all-ones and mant == 0
  - zero = expo == 0 and mant == 0
- Min compare rule, with acc as operand a and the incoming element as operand b:
  - both NaN -> a
  - one NaN -> the non-NaN operand
  - both inf -> the negative one, or a if signs are equal
  - one inf -> -inf wins, +inf loses
  - both zero -> a, regardless of sign
  - signs differ -> the negative operand
  - same sign, expo differs -> smaller expo if positive, larger expo if negative
  - same sign and expo -> smaller mant if positive, larger mant if negative
  - subnormals are compared by raw fields
- NaN results are passed through raw; there is no quieting or payload change.
- State machine:
  - IDLE: waiting for the first element. On handshake, acc <= in_data, cnt <= 1, sticky <= snan(in_data). Go to DONE if in_last, else ACC.
  - ACC: on each handshake, acc <= min(acc, in_data), cnt <= sat(cnt+1), sticky <= sticky | snan(in_data). Go to DONE if in_last.
  - DONE: out_valid = 1. out_data = acc, out_status = {sticky, 4'b0}, out_count = cnt. On out_ready, go to IDLE and clear sticky and cnt.
- in_ready = !rst && state != DONE.
- in_valid is ignored in DONE and during rst.
- cnt saturates at 2^CNT_W-1; the reduction continues correctly past saturation.
- in_last on the first element produces a single-element vector, result = that element.

## Timing
- Reset values: state IDLE, acc 0, cnt 0, sticky 0, out_valid 0, out_data 0, out_status 0, out_count 0, in_ready 0 while rst is high.
- rst asserted at any time, including mid-vector or in DONE, discards the partial or pending result. The cycle after rst deasserts, the block is in IDLE with in_ready = 1.
- Throughput: one element per cycle in IDLE/ACC.
- Latency: out_valid rises the cycle after the in_last handshake.
- An N-element vector occupies at least N+1 cycles: N accept cycles plus 1 DONE cycle.
- out_data, out_status and out_count are registered and stable while out_valid && !out_ready.
- The out handshake cycle has in_ready = 0. The next vector's first element can be accepted on the following cycle.
- The min compare is combinational from acc and in_data into the acc register. There is no pipeline bubble between consecutive elements.

## Test plan
- Basic: vector [0x40400000, 0xBFC00000, 0x40000000 last] at one per cycle -> out_valid on cycle 4, out_data 0xBFC00000, out_status 0, out_count 3.
- NaN: [0x7FC00000, 0x40A00000 last] -> 0x40A00000, status 0. [0x7FA00000, 0x3F800000 last] -> 0x3F800000, status 5'b10000. [0x7FA00000, 0x7FC00001 last] -> 0x7FA00000, status 5'b10000.
- Zeros and inf:
  - [0x00000000, 0x80000000 last] -> 0x00000000
  - reversed -> 0x80000000
  - [0x7F800000, 0xFF800000, 0xC2C80000 last] -> 0xFF800000
- Backpressure: after a result, hold out_ready = 0 for 5 cycles while in_valid = 1 -> outputs stable, in_ready = 0, no element consumed. Then release -> single-element vector [0x12345678 last] yields 0x12345678, count 1.
- Reset mid-vector: accept [0xC0000000, 0xC1000000], then assert rst for 1 cycle -> all outputs 0. Then vector [0x3F800000 last] -> 0x3F800000, status 0, count 1.
- Saturation: with CNT_W = 2, a 5-element vector ending in the smallest value 0xC0400000 -> out_count 3, out_data 0xC0400000.
